// File: rtl/gascon_pkg.sv
// ---------------------------------------------------------------------------
// gascon_pkg
// Shared definitions for the Gascon round scheduler:
//   - sched_state_t : scheduler FSM state encoding
//   - CWIDTH_DEFAULT / RWIDTH_DEFAULT : default state and round-field widths
//   - REQ_MIX / REQ_ABSORB : requester identifiers
// ---------------------------------------------------------------------------
package gascon_pkg;

    localparam int CWIDTH_DEFAULT = 320;
    localparam int RWIDTH_DEFAULT = 4;

    localparam logic REQ_MIX    = 1'b0;
    localparam logic REQ_ABSORB = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_RESP  = 3'd3,
        S_ERROR = 3'd4
    } sched_state_t;

endpackage

// File: rtl/gascon_round_scheduler_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant selection.
// Ports:
//   req[1:0] : request lines (index = requester id)
//   rr_ptr   : requester favoured when both request (the one not last served)
//   winner   : id of the selected requester (valid when any_req=1)
//   any_req  : at least one request is pending
// ---------------------------------------------------------------------------
module rr_arb2
    import gascon_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic       winner,
    output logic       any_req
);

    always_comb begin
        any_req = |req;
        winner  = REQ_MIX;
        if (req == 2'b11) begin
            winner = rr_ptr;
        end else if (req[1]) begin
            winner = REQ_ABSORB;
        end
    end

endmodule

// File: rtl/gascon_round_scheduler.sv
// ---------------------------------------------------------------------------
// gascon_round_scheduler
// Shares one Gascon core-round instance between two requesters. A round-robin
// winner's state is latched, the core is run for the requested number of
// rounds back-to-back (one LOAD + RUN pair per round), and the permuted state
// is returned on a valid/ready response. A per-round watchdog traps a stalled
// core into a sticky ERROR state that only reset leaves.
// Ports:
//   clk, reset_n              : clock (rising edge), async active-low reset
//   req, req_state, req_rounds: two request channels {1,0}
//   gnt                       : one-hot one-cycle grant pulse
//   rsp_valid/rsp_id/rsp_state/rsp_ready : result handshake
//   busy, err                 : status (err is sticky)
//   core_reset, core_c, core_round, core_cout, core_done : shared core link
// ---------------------------------------------------------------------------
module gascon_round_scheduler
    import gascon_pkg::*;
#(
    parameter int CWIDTH  = CWIDTH_DEFAULT,
    parameter int RWIDTH  = RWIDTH_DEFAULT,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          req,
    input  logic [2*CWIDTH-1:0] req_state,
    input  logic [2*RWIDTH-1:0] req_rounds,
    output logic [1:0]          gnt,
    output logic                rsp_valid,
    output logic                rsp_id,
    output logic [CWIDTH-1:0]   rsp_state,
    input  logic                rsp_ready,
    output logic                busy,
    output logic                err,
    output logic                core_reset,
    output logic [CWIDTH-1:0]   core_c,
    output logic [RWIDTH-1:0]   core_round,
    input  logic [CWIDTH-1:0]   core_cout,
    input  logic                core_done
);

    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

    sched_state_t      state, state_nx;
    logic              rr_ptr;
    logic              id_reg;
    logic [RWIDTH-1:0] rounds_reg;
    logic [RWIDTH-1:0] rnd;
    logic [WW-1:0]     wdog;
    logic [CWIDTH-1:0] st_reg;

    logic              winner;
    logic              any_req;
    logic [CWIDTH-1:0] win_state;
    logic [RWIDTH-1:0] win_rounds;
    logic              last_rnd;
    logic              err_set;

    rr_arb2 u_arb (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    assign win_state  = winner ? req_state[2*CWIDTH-1:CWIDTH]  : req_state[CWIDTH-1:0];
    assign win_rounds = winner ? req_rounds[2*RWIDTH-1:RWIDTH] : req_rounds[RWIDTH-1:0];
    // rounds_reg is non-zero whenever RUN is reached, so the subtraction never wraps there.
    assign last_rnd   = (rnd == rounds_reg - RWIDTH'(1));

    always_comb begin
        state_nx   = state;
        gnt        = 2'b00;
        rsp_valid  = 1'b0;
        rsp_id     = 1'b0;
        rsp_state  = '0;
        busy       = 1'b1;
        core_reset = 1'b1;
        core_c     = '0;
        core_round = '0;
        err_set    = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (any_req) begin
                    gnt      = winner ? 2'b10 : 2'b01;
                    state_nx = (win_rounds == '0) ? S_RESP : S_LOAD;
                end
            end
            S_LOAD: begin
                core_c     = st_reg;
                core_round = rnd;
                state_nx   = S_RUN;
            end
            S_RUN: begin
                core_reset = 1'b0;
                core_c     = st_reg;
                core_round = rnd;
                // A done arriving on the watchdog's last cycle still counts.
                if (core_done) begin
                    state_nx = last_rnd ? S_RESP : S_LOAD;
                end else if (wdog == WDOG_LAST) begin
                    err_set  = 1'b1;
                    state_nx = S_ERROR;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_id    = id_reg;
                rsp_state = st_reg;
                if (rsp_ready) begin
                    state_nx = S_IDLE;
                end
            end
            S_ERROR: begin
                state_nx = S_ERROR;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            rr_ptr     <= 1'b0;
            err        <= 1'b0;
            id_reg     <= 1'b0;
            rounds_reg <= '0;
            rnd        <= '0;
            wdog       <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        id_reg     <= winner;
                        rounds_reg <= win_rounds;
                        rnd        <= '0;
                    end
                end
                S_LOAD: begin
                    wdog <= '0;
                end
                S_RUN: begin
                    wdog <= wdog + WW'(1);
                    if (core_done && !last_rnd) begin
                        rnd <= rnd + RWIDTH'(1);
                    end
                    if (err_set) begin
                        err <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rr_ptr <= ~id_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    // Working state carries no reset: it is only observable through outputs
    // that are gated by the FSM state.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && any_req) begin
            st_reg <= win_state;
        end else if (state == S_RUN && core_done) begin
            st_reg <= core_cout;
        end
    end

endmodule
